stream_checker: RTL and testbench



---
 rtl/checker_pkg.sv | 21 ++
 rtl/stream_checker_sync_fifo.sv | 44 ++++
 rtl/stream_checker.sv | 142 ++++++++++++++
 tb/tb_stream_checker.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/checker_pkg.sv
// Shared types and the overflow-safe tolerance compare for stream_checker.
package checker_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} checker_state_t;

  // Widest sample the compare helper supports; callers sign-extend into it.
  localparam int CHK_W = 64;

  // True when |e - a| > tol. One guard bit on the difference means the most
  // negative minus the most positive sample cannot wrap.
  function automatic logic abs_diff_exceeds(input logic [CHK_W-1:0] e,
                                            input logic [CHK_W-1:0] a,
                                            input logic [CHK_W-1:0] tol);
    logic [CHK_W:0] d;
    logic [CHK_W:0] mag;
    d   = {e[CHK_W-1], e} - {a[CHK_W-1], a};
    mag = d[CHK_W] ? (~d + 1'b1) : d;
    return mag > {1'b0, tol};
  endfunction

endpackage

// File: rtl/stream_checker_sync_fifo.sv
// Expected-sample FIFO: registered storage, head visible while not empty.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             w_push, w_pop;

  assign empty  = (r_wr_ptr == r_rd_ptr);
  assign full   = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign head   = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Pointer update; flush empties the FIFO like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sample storage, no reset needed: contents are only read while not empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/stream_checker.sv
// Pairs an expected stream with an actual stream in order, compares each pair
// within a tolerance and keeps sticky pass/fail/timeout plus first-mismatch data.
module stream_checker
  import checker_pkg::*;
#(
  parameter int          DATA_WIDTH     = 24,
  parameter int          DEPTH          = 8,
  parameter int          COUNT_WIDTH    = 16,
  parameter int unsigned TOLERANCE      = 0,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] expected_count,
  input  logic [DATA_WIDTH-1:0]  exp_data,
  input  logic                   exp_valid,
  output logic                   exp_ready,
  input  logic [DATA_WIDTH-1:0]  act_data,
  input  logic                   act_valid,
  output logic                   act_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] mismatch_count,
  output logic [COUNT_WIDTH-1:0] compared_count,
  output logic [COUNT_WIDTH-1:0] first_mismatch_index,
  output logic [DATA_WIDTH-1:0]  first_mismatch_expected,
  output logic [DATA_WIDTH-1:0]  first_mismatch_actual
);
  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CHK_W-1:0] TOL_EXT = CHK_W'(TOLERANCE);

  checker_state_t         r_state, w_next;
  logic [COUNT_WIDTH-1:0] r_target, r_cmp_cnt, r_mm_cnt, r_first_idx;
  logic [DATA_WIDTH-1:0]  r_first_exp, r_first_act, w_head;
  logic [TW-1:0]          r_timer;
  logic                   r_fail, r_timeout;
  logic                   w_run, w_full, w_empty, w_push, w_pop, w_start_ok;
  logic                   w_last, w_expire, w_mismatch;
  logic [CHK_W-1:0]       w_exp_ext, w_act_ext;

  assign w_run      = (r_state == RUN);
  assign w_start_ok = start && !w_run;
  assign exp_ready  = w_run && !w_full;
  assign act_ready  = w_run && !w_empty;
  assign w_push     = exp_valid && exp_ready;
  assign w_pop      = act_valid && act_ready;
  assign w_last     = w_pop && ((r_cmp_cnt + 1'b1) == r_target);
  assign w_expire   = w_run && !w_pop && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  assign w_exp_ext  = {{(CHK_W-DATA_WIDTH){w_head[DATA_WIDTH-1]}}, w_head};
  assign w_act_ext  = {{(CHK_W-DATA_WIDTH){act_data[DATA_WIDTH-1]}}, act_data};
  assign w_mismatch = abs_diff_exceeds(w_exp_ext, w_act_ext, TOL_EXT);

  assign busy                    = w_run;
  assign done                    = (r_state == DONE);
  assign pass                    = done && !r_fail;
  assign fail                    = r_fail;
  assign timeout                 = r_timeout;
  assign mismatch_count          = r_mm_cnt;
  assign compared_count          = r_cmp_cnt;
  assign first_mismatch_index    = r_first_idx;
  assign first_mismatch_expected = r_first_exp;
  assign first_mismatch_actual   = r_first_act;

  // A new start (outside RUN) discards any leftover expected samples.
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (w_start_ok),
    .push  (w_push),
    .wdata (exp_data),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: a zero-length check completes immediately.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (expected_count == '0) ? DONE : RUN;
      RUN:        if (w_last || w_expire) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  // Status, counters, first-mismatch capture and the idle-cycle timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_target    <= '0;
      r_cmp_cnt   <= '0;
      r_mm_cnt    <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
      r_timer     <= '0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_start_ok) begin
      r_target    <= expected_count;
      r_cmp_cnt   <= '0;
      r_mm_cnt    <= '0;
      r_first_idx <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
      r_timer     <= '0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
    end else if (w_run) begin
      if (w_pop) begin
        r_timer   <= '0;
        r_cmp_cnt <= r_cmp_cnt + 1'b1;
        if (w_mismatch) begin
          r_fail <= 1'b1;
          if (r_mm_cnt != '1) r_mm_cnt <= r_mm_cnt + 1'b1;
          if (r_mm_cnt == '0) begin
            r_first_idx <= r_cmp_cnt;
            r_first_exp <= w_head;
            r_first_act <= act_data;
          end
        end
      end else if (w_expire) begin
        r_timeout <= 1'b1;
        r_fail    <= 1'b1;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: table of whole-check vectors plus
// hand-written sequences for FIFO backpressure and mid-run reset.
module tb_stream_checker;
  localparam int DW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [CW-1:0] expected_count;
  logic [DW-1:0] exp_data, act_data;
  logic          exp_valid, act_valid, exp_ready, act_ready;
  logic          busy, done, pass, fail, timeout;
  logic [CW-1:0] mismatch_count, compared_count, first_mismatch_index;
  logic [DW-1:0] first_mismatch_expected, first_mismatch_actual;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_checker #(
    .DATA_WIDTH(DW), .DEPTH(8), .COUNT_WIDTH(CW), .TOLERANCE(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .expected_count(expected_count),
    .exp_data(exp_data), .exp_valid(exp_valid), .exp_ready(exp_ready),
    .act_data(act_data), .act_valid(act_valid), .act_ready(act_ready),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .mismatch_count(mismatch_count), .compared_count(compared_count),
    .first_mismatch_index(first_mismatch_index),
    .first_mismatch_expected(first_mismatch_expected),
    .first_mismatch_actual(first_mismatch_actual)
  );

  typedef struct {
    int cnt; int ne; int na;
    int e[5]; int a[5];
    int ps; int fl; int to; int mm; int cmp; int fidx; int fe; int fa;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ei, ai, cyc;
    logic [DW-1:0] fe, fa;
    @(negedge clk);
    start = 1'b1; expected_count = CW'(v.cnt);
    @(negedge clk);
    start = 1'b0;
    ei = 0; ai = 0; cyc = 0;
    while (!done && cyc < 200) begin
      exp_valid = (ei < v.ne);
      exp_data  = (ei < 5) ? DW'(v.e[ei]) : '0;
      act_valid = (ai < v.na);
      act_data  = (ai < 5) ? DW'(v.a[ai]) : '0;
      #1;
      if (exp_valid && exp_ready) ei++;
      if (act_valid && act_ready) ai++;
      @(negedge clk);
      cyc++;
    end
    exp_valid = 1'b0; act_valid = 1'b0;
    fe = DW'(v.fe); fa = DW'(v.fa);
    chk($sformatf("v%0d done", idx), done, 1);
    chk($sformatf("v%0d pass", idx), pass, v.ps[0]);
    chk($sformatf("v%0d fail", idx), fail, v.fl[0]);
    chk($sformatf("v%0d timeout", idx), timeout, v.to[0]);
    chk($sformatf("v%0d mismatch_count", idx), mismatch_count, CW'(v.mm));
    chk($sformatf("v%0d compared_count", idx), compared_count, CW'(v.cmp));
    chk($sformatf("v%0d first_index", idx), first_mismatch_index, CW'(v.fidx));
    chk($sformatf("v%0d first_expected", idx), first_mismatch_expected, fe);
    chk($sformatf("v%0d first_actual", idx), first_mismatch_actual, fa);
  endtask

  initial begin
    vecs[0] = '{cnt:4, ne:4, na:4, e:'{10,20,30,40,0}, a:'{10,20,30,40,0},
                ps:1, fl:0, to:0, mm:0, cmp:4, fidx:0, fe:0, fa:0};
    vecs[1] = '{cnt:3, ne:3, na:3, e:'{5,6,7,0,0}, a:'{5,9,7,0,0},
                ps:0, fl:1, to:0, mm:1, cmp:3, fidx:1, fe:6, fa:9};
    vecs[2] = '{cnt:2, ne:2, na:2, e:'{-8388608,100,0,0,0}, a:'{8388607,102,0,0,0},
                ps:0, fl:1, to:0, mm:1, cmp:2, fidx:0, fe:-8388608, fa:8388607};
    vecs[3] = '{cnt:5, ne:5, na:2, e:'{1,2,3,4,5}, a:'{1,2,0,0,0},
                ps:0, fl:1, to:1, mm:0, cmp:2, fidx:0, fe:0, fa:0};
    vecs[4] = '{cnt:1, ne:1, na:1, e:'{7,0,0,0,0}, a:'{7,0,0,0,0},
                ps:1, fl:0, to:0, mm:0, cmp:1, fidx:0, fe:0, fa:0};
    vecs[5] = '{cnt:0, ne:0, na:0, e:'{0,0,0,0,0}, a:'{0,0,0,0,0},
                ps:1, fl:0, to:0, mm:0, cmp:0, fidx:0, fe:0, fa:0};
    vecs[6] = '{cnt:1, ne:1, na:1, e:'{1,0,0,0,0}, a:'{1,0,0,0,0},
                ps:1, fl:0, to:0, mm:0, cmp:1, fidx:0, fe:0, fa:0};
    vecs[7] = '{cnt:3, ne:3, na:3, e:'{0,0,0,0,0}, a:'{0,3,-3,0,0},
                ps:0, fl:1, to:0, mm:2, cmp:3, fidx:1, fe:0, fa:3};

    reset = 1'b1; start = 1'b0; expected_count = '0;
    exp_data = '0; exp_valid = 1'b0; act_data = '0; act_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset pass", pass, 0);
    chk("reset exp_ready", exp_ready, 0);
    chk("reset compared_count", compared_count, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Fill the FIFO with no actual samples, then check the full/pop interplay.
    @(negedge clk);
    start = 1'b1; expected_count = CW'(2);
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      exp_valid = 1'b1; exp_data = DW'(k); act_valid = 1'b0;
      #1 chk($sformatf("fill exp_ready %0d", k), exp_ready, 1);
      @(negedge clk);
    end
    exp_data = DW'(100);
    #1;
    chk("full exp_ready", exp_ready, 0);
    chk("full act_ready", act_ready, 1);
    act_valid = 1'b1; act_data = DW'(1);
    @(negedge clk);
    #1;
    chk("after pop exp_ready", exp_ready, 1);
    chk("after pop compared_count", compared_count, 1);
    act_data = DW'(2);
    @(negedge clk);
    exp_valid = 1'b0; act_valid = 1'b0;
    chk("fill done", done, 1);
    chk("fill pass", pass, 1);
    chk("fill compared_count", compared_count, 2);

    // Build up some status mid-run, then reset and expect everything cleared.
    @(negedge clk);
    start = 1'b1; expected_count = CW'(3);
    @(negedge clk);
    start = 1'b0;
    exp_valid = 1'b1; exp_data = DW'(50);
    @(negedge clk);
    exp_valid = 1'b0; act_valid = 1'b1; act_data = DW'(60);
    @(negedge clk);
    act_valid = 1'b0;
    chk("midrun busy", busy, 1);
    chk("midrun fail", fail, 1);
    chk("midrun mismatch_count", mismatch_count, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst pass", pass, 0);
    chk("rst fail", fail, 0);
    chk("rst timeout", timeout, 0);
    chk("rst exp_ready", exp_ready, 0);
    chk("rst act_ready", act_ready, 0);
    chk("rst mismatch_count", mismatch_count, 0);
    chk("rst compared_count", compared_count, 0);
    chk("rst first_index", first_mismatch_index, 0);
    chk("rst first_expected", first_mismatch_expected, 0);
    chk("rst first_actual", first_mismatch_actual, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
